// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply result path: run-state encoding,
// data width and the saturating counter helper.
package mm_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STAT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mm_state_e;

   // Add without wrapping; sticks at all-ones.
   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [STAT_W-1:0] b);
      logic [STAT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[STAT_W] ? '1 : s[STAT_W-1:0];
   endfunction

endpackage

// File: rtl/result_write_arbiter_rr_arbiter.sv
// Combinational round-robin grant: picks the first requester at or after i_ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt_c,
   output logic [PTR_W-1:0]   o_idx_c,
   output logic               o_valid_c
);

   function automatic logic [PTR_W-1:0] f_pos(input logic [PTR_W-1:0] ptr,
                                              input int unsigned     k);
      int unsigned s;
      s = 32'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   logic w_found;

   always_comb begin
      o_gnt_c = '0;
      o_idx_c = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!w_found && i_req[f_pos(i_ptr, k)]) begin
            w_found                   = 1'b1;
            o_gnt_c[f_pos(i_ptr, k)]  = 1'b1;
            o_idx_c                   = f_pos(i_ptr, k);
         end
      end
      o_valid_c = w_found;
   end

endmodule

// File: rtl/result_write_arbiter.sv
// Shares one result-memory write port among NUM_REQ tile multipliers with a
// registered round-robin grant. Optional counters behind RESULT_ARB_STATS_EN.
module result_write_arbiter
   import mm_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned n       = 10,
   localparam int unsigned IDX_W   = (n > 1) ? $clog2(n) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        mul_start,
   input  logic [NUM_REQ-1:0]          req_stb,
   input  logic [NUM_REQ*IDX_W-1:0]    req_i,
   input  logic [NUM_REQ*IDX_W-1:0]    req_j,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_done,
   output logic [NUM_REQ-1:0]          req_ack,
   output logic                        wr_en,
   output logic [IDX_W-1:0]            wr_i,
   output logic [IDX_W-1:0]            wr_j,
   output logic [DATA_W-1:0]           wr_data,
   output logic                        busy,
   output logic                        done
`ifdef RESULT_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]           write_count,
   output logic [STAT_W-1:0]           stall_count
`endif
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   mm_state_e            r_state, w_next;
   logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
   logic [NUM_REQ-1:0]   r_ack, w_elig, w_gnt;
   logic [PTR_W-1:0]     w_gnt_idx;
   logic                 w_gnt_vld, w_start_acc;
   logic                 r_mul_start, r_wr_en, r_busy, r_done;
   logic [IDX_W-1:0]     r_wr_i, r_wr_j, w_sel_i, w_sel_j;
   logic [DATA_W-1:0]    r_wr_data, w_sel_data;

   assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if ((&req_done) && !(|req_stb) && !r_wr_en) w_next = DONE;
         DONE:    if (start) w_next = RUN;
         default: w_next = IDLE;
      endcase
   end

   // Last cycle's grantee is locked out so a strobe held through its ack is not rewritten.
   assign w_elig = (r_state == RUN) ? (req_stb & ~r_ack) : '0;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .i_req     (w_elig),
      .i_ptr     (r_ptr),
      .o_gnt_c   (w_gnt),
      .o_idx_c   (w_gnt_idx),
      .o_valid_c (w_gnt_vld)
   );

   assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

   always_comb begin
      w_sel_i    = '0;
      w_sel_j    = '0;
      w_sel_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (w_gnt[k]) begin
            w_sel_i    = req_i[k*IDX_W +: IDX_W];
            w_sel_j    = req_j[k*IDX_W +: IDX_W];
            w_sel_data = req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_ack       <= '0;
         r_mul_start <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_i      <= '0;
         r_wr_j      <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_mul_start <= w_start_acc;
         r_busy      <= (w_next == RUN);
         r_done      <= (w_next == DONE);
         r_ack       <= w_gnt;
         r_wr_en     <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_wr_i    <= w_sel_i;
            r_wr_j    <= w_sel_j;
            r_wr_data <= w_sel_data;
            r_ptr     <= w_ptr_nxt;
         end
      end
   end

   assign mul_start = r_mul_start;
   assign req_ack   = r_ack;
   assign wr_en     = r_wr_en;
   assign wr_i      = r_wr_i;
   assign wr_j      = r_wr_j;
   assign wr_data   = r_wr_data;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef RESULT_ARB_STATS_EN
   logic [STAT_W-1:0]  r_write_count, r_stall_count, w_stall_n;
   logic [NUM_REQ-1:0] w_stall;

   assign w_stall = (r_state == RUN) ? (req_stb & ~w_gnt) : '0;

   always_comb begin
      w_stall_n = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_stall_n = w_stall_n + STAT_W'(w_stall[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_start_acc) begin
         r_write_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (r_wr_en) r_write_count <= sat_add(r_write_count, STAT_W'(1));
         r_stall_count <= sat_add(r_stall_count, w_stall_n);
      end
   end

   assign write_count = r_write_count;
   assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_result_write_arbiter.sv
// Directed bench for result_write_arbiter with a write scoreboard; also checks
// the counters when built with RESULT_ARB_STATS_EN.
module tb_result_write_arbiter;
   import mm_pkg::*;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned N       = 10;
   localparam int unsigned IDX_W   = $clog2(N);

   logic                      clk = 1'b0;
   logic                      rst, start, mul_start;
   logic [NUM_REQ-1:0]        req_stb, req_done, req_ack;
   logic [NUM_REQ*IDX_W-1:0]  req_i, req_j;
   logic [NUM_REQ*32-1:0]     req_data;
   logic                      wr_en, busy, done;
   logic [IDX_W-1:0]          wr_i, wr_j;
   logic [31:0]               wr_data;
`ifdef RESULT_ARB_STATS_EN
   logic [15:0]               write_count, stall_count;
`endif

   always #5 clk = ~clk;

   result_write_arbiter #(.NUM_REQ(NUM_REQ), .n(N)) dut (
      .clk(clk), .rst(rst), .start(start), .mul_start(mul_start),
      .req_stb(req_stb), .req_i(req_i), .req_j(req_j), .req_data(req_data),
      .req_done(req_done), .req_ack(req_ack),
      .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data),
      .busy(busy), .done(done)
`ifdef RESULT_ARB_STATS_EN
      , .write_count(write_count), .stall_count(stall_count)
`endif
   );

   typedef struct {
      int unsigned      idx;
      logic [IDX_W-1:0] i;
      logic [IDX_W-1:0] j;
      logic [31:0]      d;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_writes = 0;
   int   ack_cnt[NUM_REQ];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Every write must match the oldest expected entry; no ack without a write.
   task automatic monitor();
      exp_t e;
      if (wr_en) begin
         n_writes++;
         for (int k = 0; k < NUM_REQ; k++) if (req_ack[k]) ack_cnt[k]++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(wr_en), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_ack",  32'(req_ack), 32'(1 << e.idx));
            check("wr_i",    32'(wr_i),    32'(e.i));
            check("wr_j",    32'(wr_j),    32'(e.j));
            check("wr_data", wr_data,      e.d);
         end
      end else if (req_ack !== '0) begin
         check("ack_without_write", 32'(req_ack), 32'd0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1 monitor();
      #1;
   endtask

   task automatic set_slot(input int k, input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j,
                           input logic [31:0] d);
      req_i[k*IDX_W +: IDX_W] = i;
      req_j[k*IDX_W +: IDX_W] = j;
      req_data[k*32 +: 32]    = d;
   endtask

   task automatic push(input int unsigned k, input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j,
                       input logic [31:0] d);
      exp_t e;
      e.idx = k; e.i = i; e.j = j; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_mul_start_hi"}, 32'(mul_start), 32'd1);
      check({tag, "_busy_hi"},      32'(busy),      32'd1);
      check({tag, "_done_lo"},      32'(done),      32'd0);
      tick();
      check({tag, "_mul_start_lo"}, 32'(mul_start), 32'd0);
      check({tag, "_busy_hold"},    32'(busy),      32'd1);
   endtask

   // Requesters drop their strobe once they see their ack.
   task automatic drain(input string tag, input int budget);
      int cyc;
      cyc = 0;
      while ((req_stb != '0 || exp_q.size() != 0) && cyc < budget) begin
         tick();
         req_stb = req_stb & ~req_ack;
         cyc++;
      end
      if (req_stb != '0 || exp_q.size() != 0)
         check({tag, "_timeout_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int w0;
      rst = 1'b1; start = 1'b0; req_stb = '0; req_done = '0;
      req_i = '0; req_j = '0; req_data = '0;
      for (int k = 0; k < NUM_REQ; k++) ack_cnt[k] = 0;
      repeat (2) tick();
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_ack",       32'(req_ack),   32'd0);
      check("rst_wr_en",     32'(wr_en),     32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_wr_data",   wr_data,        32'd0);
      rst = 1'b0;
      tick();

      // Strobes in IDLE are ignored
      set_slot(0, 4'd1, 4'd2, 32'h11);
      req_stb = 4'b0001;
      tick(); tick();
      check("idle_stb_no_write", 32'(wr_en), 32'd0);
      req_stb = '0;

      do_start("start1");
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_start_ignored", 32'(mul_start), 32'd0);

      // Four simultaneous strobes: acks 0,1,2,3 from a reset pointer
      for (int k = 0; k < NUM_REQ; k++) begin
         set_slot(k, IDX_W'(k + 1), IDX_W'(9 - k), 32'hA0 + 32'(k));
         push(k, IDX_W'(k + 1), IDX_W'(9 - k), 32'hA0 + 32'(k));
         ack_cnt[k] = 0;
      end
      w0 = n_writes;
      req_stb = 4'b1111;
      drain("all4", 12);
      for (int k = 0; k < NUM_REQ; k++) check("all4_ack_once", 32'(ack_cnt[k]), 32'd1);
      check("all4_write_total", 32'(n_writes - w0), 32'd4);
      tick();
`ifdef RESULT_ARB_STATS_EN
      check("stats_write_count", 32'(write_count), 32'd4);
      check("stats_stall_count", 32'(stall_count), 32'd6);
`endif

      // Held strobe through its ack cycle is written once
      set_slot(2, 4'd3, 4'd7, 32'h0000_002A);
      push(2, 4'd3, 4'd7, 32'h0000_002A);
      w0 = n_writes;
      req_stb = 4'b0100;
      tick();
      check("hold_ack2", 32'(req_ack), 32'b0100);
      tick();
      check("hold_lockout_no_wr", 32'(wr_en), 32'd0);
      req_stb = '0;
      tick(); tick();
      check("hold_single_write", 32'(n_writes - w0), 32'd1);

      // Lone requester strobing every other cycle gets no stall
      for (int r = 0; r < 3; r++) begin
         set_slot(1, IDX_W'(r + 4), IDX_W'(r), 32'h100 + 32'(r));
         push(1, IDX_W'(r + 4), IDX_W'(r), 32'h100 + 32'(r));
         req_stb = 4'b0010;
         tick();
         check("alt_ack1", 32'(req_ack), 32'b0010);
         req_stb = '0;
         tick();
      end
      check("hold_wr_en_lo",   32'(wr_en), 32'd0);
      check("hold_wr_data",    wr_data,    32'h102);
      check("hold_wr_i",       32'(wr_i),  32'd6);

      // Pointer sits at 2: requesters 0 and 1 served as 0 then 1
      set_slot(0, 4'd8, 4'd8, 32'hDEAD_0000);
      set_slot(1, 4'd9, 4'd0, 32'hBEEF_0001);
      push(0, 4'd8, 4'd8, 32'hDEAD_0000);
      push(1, 4'd9, 4'd0, 32'hBEEF_0001);
      req_stb = 4'b0011;
      drain("wrap", 8);

      // All tiles done, nothing strobing
      tick();
      req_done = 4'b1111;
      tick();
      check("done_hi",  32'(done), 32'd1);
      check("done_busy_lo", 32'(busy), 32'd0);
      req_stb = 4'b0001;
      tick();
      check("done_stb_ignored", 32'(wr_en), 32'd0);
      req_stb  = '0;
      req_done = '0;
      do_start("restart");
`ifdef RESULT_ARB_STATS_EN
      check("stats_cleared_on_start", 32'(write_count), 32'd0);
`endif

      // Reset mid-RUN with three strobes pending, then reset beats start
      req_stb = 4'b0111;
      rst = 1'b1;
      tick();
      check("midrst_busy",    32'(busy),    32'd0);
      check("midrst_done",    32'(done),    32'd0);
      check("midrst_ack",     32'(req_ack), 32'd0);
      check("midrst_wr_en",   32'(wr_en),   32'd0);
      check("midrst_wr_i",    32'(wr_i),    32'd0);
      check("midrst_wr_j",    32'(wr_j),    32'd0);
      check("midrst_wr_data", wr_data,      32'd0);
      start = 1'b1;
      tick();
      check("rst_over_start_mul", 32'(mul_start), 32'd0);
      check("rst_over_start_busy", 32'(busy), 32'd0);
      rst = 1'b0; start = 1'b0; req_stb = '0;
      tick();
      check("post_rst_idle_busy", 32'(busy), 32'd0);
      do_start("start3");

      // Pointer cleared: 1 wins over 3
      set_slot(1, 4'd2, 4'd5, 32'h5555_0001);
      set_slot(3, 4'd4, 4'd6, 32'h5555_0003);
      push(1, 4'd2, 4'd5, 32'h5555_0001);
      push(3, 4'd4, 4'd6, 32'h5555_0003);
      req_stb = 4'b1010;
      drain("ptr_reset", 8);

      repeat (3) tick();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
